// File: rtl/antares_branch_predictor_pkg.sv
// Shared definitions for the antares branch predictor: 2-bit counter encodings
// and the saturating update helpers used when training the BTB.
package antares_branch_predictor_pkg;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] cnt);
        return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] cnt);
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/antares_branch_predictor_btb_ram.sv
// Branch target buffer storage: valid bits in resettable flops, tag/target/counter
// arrays unreset. Asynchronous reads, one synchronous write port.
module antares_branch_predictor_btb_ram #(
    parameter int IDX      = 6,
    parameter int TAG_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX-1:0]      lookup_idx,
    output logic                lookup_valid,
    output logic [TAG_BITS-1:0] lookup_tag,
    output logic [31:0]         lookup_target,
    output logic [1:0]          lookup_cnt,
    input  logic [IDX-1:0]      train_idx,
    output logic                train_valid,
    output logic [TAG_BITS-1:0] train_tag,
    output logic [1:0]          train_cnt,
    input  logic                wr_en,
    input  logic                wr_target_en,
    input  logic [IDX-1:0]      wr_idx,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [31:0]         wr_target,
    input  logic [1:0]          wr_cnt
);

    localparam int ENTRIES = 1 << IDX;

    logic [ENTRIES-1:0]  valid;
    logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
    logic [31:0]         target_mem [ENTRIES];
    logic [1:0]          cnt_mem    [ENTRIES];

    // The training side needs its own read of the entry in ID, since it may differ from the IF entry.
    assign lookup_valid  = valid[lookup_idx];
    assign lookup_tag    = tag_mem[lookup_idx];
    assign lookup_target = target_mem[lookup_idx];
    assign lookup_cnt    = cnt_mem[lookup_idx];
    assign train_valid   = valid[train_idx];
    assign train_tag     = tag_mem[train_idx];
    assign train_cnt     = cnt_mem[train_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_mem[wr_idx] <= wr_tag;
            cnt_mem[wr_idx] <= wr_cnt;
            if (wr_target_en) begin
                target_mem[wr_idx] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/antares_branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with 2-bit counters, IF-stage lookup,
// ID-stage mispredict check with recovery PC, and table training from resolved branches.
module antares_branch_predictor
    import antares_branch_predictor_pkg::*;
#(
    parameter int         ENTRIES  = 64,
    parameter logic [1:0] CNT_INIT = CNT_WT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    input  logic        if_stall,
    input  logic        if_flush,
    output logic        if_predict_taken,
    output logic [31:0] if_predict_target,
    input  logic [31:0] id_pc,
    input  logic        id_is_branch,
    input  logic        id_uncond,
    input  logic        id_take_branch,
    input  logic [31:0] id_branch_target,
    input  logic        id_stall,
    output logic        id_mispredict,
    output logic [31:0] id_recover_pc
);

    localparam int IDX      = $clog2(ENTRIES);
    localparam int TAG_BITS = 30 - IDX;

    logic                lookup_valid;
    logic [TAG_BITS-1:0] lookup_tag;
    logic [31:0]         lookup_target;
    logic [1:0]          lookup_cnt;
    logic                lookup_hit;
    logic                train_valid;
    logic [TAG_BITS-1:0] train_tag;
    logic [1:0]          train_cnt;
    logic                train_hit;
    logic                active;
    logic                wr_en;
    logic                wr_target_en;
    logic [1:0]          wr_cnt;
    logic                pred_taken_q;
    logic [31:0]         pred_target_q;
    logic                unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], id_pc[1:0]};

    antares_branch_predictor_btb_ram #(
        .IDX      (IDX),
        .TAG_BITS (TAG_BITS)
    ) u_btb_ram (
        .clk           (clk),
        .rst           (rst),
        .lookup_idx    (if_pc[IDX+1:2]),
        .lookup_valid  (lookup_valid),
        .lookup_tag    (lookup_tag),
        .lookup_target (lookup_target),
        .lookup_cnt    (lookup_cnt),
        .train_idx     (id_pc[IDX+1:2]),
        .train_valid   (train_valid),
        .train_tag     (train_tag),
        .train_cnt     (train_cnt),
        .wr_en         (wr_en),
        .wr_target_en  (wr_target_en),
        .wr_idx        (id_pc[IDX+1:2]),
        .wr_tag        (id_pc[31:IDX+2]),
        .wr_target     (id_branch_target),
        .wr_cnt        (wr_cnt)
    );

    assign lookup_hit        = !rst && lookup_valid && (lookup_tag == if_pc[31:IDX+2]);
    assign if_predict_taken  = lookup_hit && lookup_cnt[1];
    assign if_predict_target = lookup_hit ? lookup_target : 32'd0;

    always_ff @(posedge clk) begin
        if (rst || if_flush) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= 32'd0;
        end else if (!if_stall) begin
            pred_taken_q  <= if_predict_taken;
            pred_target_q <= if_predict_target;
        end
    end

    assign active        = id_is_branch && !id_stall && !rst;
    assign id_mispredict = active && ((id_take_branch != pred_taken_q) ||
                                      (id_take_branch && (id_branch_target != pred_target_q)));
    assign id_recover_pc = id_take_branch ? id_branch_target : id_pc + 32'd4;

    assign train_hit = train_valid && (train_tag == id_pc[31:IDX+2]);

    // A not-taken resolve only allocates nothing; a hit keeps its target unless taken.
    always_comb begin
        wr_en        = 1'b0;
        wr_target_en = 1'b0;
        wr_cnt       = train_cnt;
        if (active) begin
            if (train_hit) begin
                wr_en        = 1'b1;
                wr_target_en = id_take_branch;
                if (id_uncond) begin
                    wr_cnt = CNT_ST;
                end else if (id_take_branch) begin
                    wr_cnt = sat_inc(train_cnt);
                end else begin
                    wr_cnt = sat_dec(train_cnt);
                end
            end else if (id_take_branch) begin
                wr_en        = 1'b1;
                wr_target_en = 1'b1;
                wr_cnt       = id_uncond ? CNT_ST : CNT_INIT;
            end
        end
    end

endmodule
